// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the signals exchanged between the RV32 pipeline datapath and the
//   central hazard controller.
//
//   master : the pipeline datapath. It reports ID/EX instruction information
//            and receives the stall/flush/bubble controls and debug counters.
//   slave  : the hazard controller (pipeline_hazard_ctrl).
//
//   Datapath -> controller
//     id_rs1, id_rs2          source registers of the instruction in ID
//     id_uses_rs1/rs2         ID instruction really reads rs1/rs2
//     ex_rd                   destination register of the instruction in EX
//     ex_mem_read             EX instruction is a load
//     ex_redirect             EX resolved a taken branch/jump this cycle
//     ex_div_start            EX instruction is a divide/remainder
//   Controller -> datapath
//     pc_stall, if_id_stall   hold PC / IF-ID
//     if_id_flush             IF/ID loads a NOP
//     id_ex_bubble            ID/EX loads all-zero controls
//     ex_hold                 hold ID/EX contents and the EX operation
//     ex_mem_flush            EX/MEM loads all-zero controls
//     div_done                last EX cycle of a divide, result valid
//     stall_count             saturating count of pc_stall cycles
//     redirect_count          saturating count of accepted redirects
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_redirect;
    logic        ex_div_start;

    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_hold;
    logic        ex_mem_flush;
    logic        div_done;
    logic [31:0] stall_count;
    logic [31:0] redirect_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, ex_redirect, ex_div_start,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               ex_hold, ex_mem_flush, div_done, stall_count, redirect_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, ex_redirect, ex_div_start,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               ex_hold, ex_mem_flush, div_done, stall_count, redirect_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central hazard and sequencing controller for the 5-stage RV32 pipeline.
//   Generates stall/flush/bubble controls for PC, IF/ID, ID/EX and EX/MEM
//   covering load-use hazards, taken branch/jump redirects and multi-cycle
//   divides, and keeps saturating stall/redirect event counters.
//
//   Parameters
//     DIV_CYCLES    total cycles a divide occupies EX (2..64)
//     FLUSH_CYCLES  extra IF/ID flush cycles after a redirect (0..7)
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     hz     pipeline_hazard_ctrl_if.slave (datapath status in, controls out)
//
//   Controls are combinational from state, the shared down-counter and the
//   current inputs; only the event counters are registered outputs.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES   = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_ctrl_if.slave        hz
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        DIV_BUSY,
        REDIRECT
    } state_e;

    // The start cycle already counts as one divide cycle and the final
    // cnt==0 cycle is the div_done cycle, hence the -2.
    localparam logic [5:0] DIV_CNT_INIT   = 6'(DIV_CYCLES - 2);
    localparam logic [5:0] FLUSH_CNT_INIT = (FLUSH_CYCLES == 0) ? 6'd0
                                                                 : 6'(FLUSH_CYCLES - 1);
    localparam logic [31:0] COUNT_MAX     = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q;
    logic [31:0] redirect_count_q;

    logic        load_use;
    logic        redirect_accept;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_hold;
    logic        ex_mem_flush;
    logic        div_done;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        redirect_accept = 1'b0;
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_hold         = 1'b0;
        ex_mem_flush    = 1'b0;
        div_done        = 1'b0;

        if (reset) begin
            // Keep the pipeline registers loading NOPs while reset is held.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    // Priority: redirect, then divide, then load-use. The
                    // younger instructions are wrong-path after a redirect,
                    // so their hazards are irrelevant.
                    if (hz.ex_redirect) begin
                        if_id_flush     = 1'b1;
                        id_ex_bubble    = 1'b1;
                        redirect_accept = 1'b1;
                        if (FLUSH_CYCLES != 0) begin
                            state_d = REDIRECT;
                            cnt_d   = FLUSH_CNT_INIT;
                        end
                    end else if (hz.ex_div_start) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        ex_hold      = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_d      = DIV_BUSY;
                        cnt_d        = DIV_CNT_INIT;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = LOAD_STALL;
                    end
                end

                LOAD_STALL: begin
                    // The load has moved to MEM; forwarding covers the use.
                    state_d = RUN;
                end

                DIV_BUSY: begin
                    if (cnt_q != 6'd0) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        ex_hold      = 1'b1;
                        ex_mem_flush = 1'b1;
                        cnt_d        = cnt_q - 6'd1;
                    end else begin
                        // Result leaves EX this cycle; the pipeline advances
                        // so a following divide can start next cycle.
                        div_done = 1'b1;
                        state_d  = RUN;
                    end
                end

                REDIRECT: begin
                    // Covers instruction-RAM latency: wrong-path fetches
                    // still arriving are squashed.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before this edge, independent of block order.
        if (reset) begin
            state_q          <= RUN;
            cnt_q            <= 6'd0;
            stall_count_q    <= 32'd0;
            redirect_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_stall && (stall_count_q != COUNT_MAX)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (redirect_accept && (redirect_count_q != COUNT_MAX)) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
        end
    end

    assign hz.pc_stall       = pc_stall;
    assign hz.if_id_stall    = if_id_stall;
    assign hz.if_id_flush    = if_id_flush;
    assign hz.id_ex_bubble   = id_ex_bubble;
    assign hz.ex_hold        = ex_hold;
    assign hz.ex_mem_flush   = ex_mem_flush;
    assign hz.div_done       = div_done;
    assign hz.stall_count    = stall_count_q;
    assign hz.redirect_count = redirect_count_q;

endmodule
